hex_display_driver: RTL and testbench

Parametrised multi-digit hexadecimal display driver for the board's 7-segment bank. It replaces per-digit combinational decoders with one shared glyph decoder that scans the digits serially. It adds a load/busy/done handshake, atomic display update, optional leading-zero blanking and per-digit blinking. It sits between any datapath that produces a packed hex value and the HEX outputs.

---
 rtl/hex_disp_pkg.sv | 18 +
 rtl/hex_display_driver_if.sv | 22 ++
 rtl/seg7_glyph.sv | 9 +
 rtl/hex_display_driver.sv | 123 ++++++++++++
 tb/tb_hex_display_driver.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the serial-scan hex display driver.
// Glyphs are active-high with bit0 = segment a through bit6 = segment g.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } disp_state_e;

    localparam logic [6:0] SEG_DARK = 7'h00;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_display_driver_if.sv
// Load/busy/done handshake plus packed value and segment outputs.
interface hex_display_driver_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    busy;
    logic                    done;
    logic [7*NUM_DIGITS-1:0] hex;

    modport master (
        output load, value, blank_lz, blink_mask,
        input  busy, done, hex
    );

    modport slave (
        input  load, value, blank_lz, blink_mask,
        output busy, done, hex
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder, active-high segments.
module seg7_glyph
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);
    assign glyph = GLYPH_TABLE[nibble];
endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: one shared decoder scans digits MSB-first into a
// staging buffer, then commits the whole pattern at once; per-digit blink on output.
module hex_display_driver
    import hex_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic                 clock,
    input logic                 reset,
    hex_display_driver_if.slave bus
);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned ValW = 4 * NUM_DIGITS;
    localparam int unsigned SegW = 7 * NUM_DIGITS;

    disp_state_e           state_q, state_d;
    logic [ValW-1:0]       value_q;
    logic [NUM_DIGITS-1:0] mask_sh_q;
    logic [NUM_DIGITS-1:0] mask_q;
    logic                  lz_run_q;
    logic [IdxW-1:0]       idx_q;
    logic [SegW-1:0]       stage_q;
    logic [SegW-1:0]       pattern_q;
    logic [CntW-1:0]       blink_cnt_q;
    logic                  phase_q;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic                  slot_blank;
    logic [6:0]            seg;
    logic [SegW-1:0]       hex_out;

    assign nibble = value_q[4*idx_q +: 4];

    seg7_glyph u_glyph (
        .nibble (nibble),
        .glyph  (glyph)
    );

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign slot_blank = lz_run_q && (nibble == 4'h0) && (idx_q != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = SCAN;
            SCAN:    if (idx_q == '0) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q   <= '0;
            mask_sh_q <= '0;
            mask_q    <= '0;
            lz_run_q  <= 1'b0;
            idx_q     <= '0;
            stage_q   <= '0;
            pattern_q <= {NUM_DIGITS{SEG_DARK}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        value_q   <= bus.value;
                        mask_sh_q <= bus.blink_mask;
                        lz_run_q  <= bus.blank_lz;
                        idx_q     <= IdxW'(NUM_DIGITS - 1);
                    end
                end
                SCAN: begin
                    stage_q[7*idx_q +: 7] <= slot_blank ? SEG_DARK : glyph;
                    lz_run_q              <= slot_blank;
                    if (idx_q != '0) idx_q <= idx_q - 1'b1;
                end
                COMMIT: begin
                    pattern_q <= stage_q;
                    mask_q    <= mask_sh_q;
                end
                default: ;
            endcase
        end
    end

    // Free-running blink timebase, deliberately untouched by load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == CntW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        hex_out = '0;
        seg     = SEG_DARK;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            seg = pattern_q[7*i +: 7];
            if (mask_q[i] && phase_q) seg = SEG_DARK;
            hex_out[7*i +: 7] = ACTIVE_LOW ? ~seg : seg;
        end
    end

    assign bus.hex  = hex_out;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == COMMIT);

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench: vector table, random loads against a digit-level model,
// and hand sequences for blink, ignored load and mid-scan reset.
module tb_hex_display_driver;
    localparam int unsigned N  = 4;
    localparam int unsigned BD = 4;
    localparam logic [27:0] DARK = 28'hFFFFFFF;

    localparam logic [6:0] SEGS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [15:0] value;
        logic        blz;
        logic [27:0] exp_hex;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    int unsigned edges;

    logic        cur_valid;
    logic [15:0] cur_v;
    logic        cur_blz;
    logic [3:0]  cur_mask;

    always #5 clock = ~clock;

    hex_display_driver_if #(.NUM_DIGITS(N)) bus ();

    hex_display_driver #(
        .NUM_DIGITS (N),
        .BLINK_DIV  (BD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Edges since reset release; blink phase follows from this count alone.
    always @(posedge clock or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic phase_now();
        return ((edges / BD) % 2) == 1;
    endfunction

    function automatic logic [27:0] model_hex(logic [15:0] v, logic blz, logic [3:0] mask,
                                              logic ph);
        logic [27:0] r;
        logic [6:0]  g;
        int          top_nz;
        r = '0;
        top_nz = 0;
        for (int i = 0; i < int'(N); i++) if (v[4*i +: 4] != 4'h0) top_nz = i;
        for (int i = 0; i < int'(N); i++) begin
            g = SEGS[v[4*i +: 4]];
            if (blz && i > top_nz) g = 7'h00;
            if (mask[i] && ph) g = 7'h00;
            r[7*i +: 7] = ~g;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_disp();
        if (!cur_valid) return DARK;
        return model_hex(cur_v, cur_blz, cur_mask, phase_now());
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic blz, input logic [3:0] mask);
        @(negedge clock);
        bus.load       = 1'b1;
        bus.value      = v;
        bus.blank_lz   = blz;
        bus.blink_mask = mask;
        @(negedge clock);
        bus.load = 1'b0;
    endtask

    // Returns at the negedge of the first cycle the new pattern should be visible.
    task automatic load_and_check(input string name, input logic [15:0] v, input logic blz,
                                  input logic [3:0] mask, input logic use_const,
                                  input logic [27:0] const_exp);
        do_load(v, blz, mask);
        for (int c = 1; c <= int'(N) + 1; c++) begin
            check({name, " busy"}, 32'(bus.busy), 32'd1);
            check({name, " done"}, 32'(bus.done), 32'(c == int'(N) + 1));
            check({name, " hex held"}, 32'(bus.hex), 32'(exp_disp()));
            @(negedge clock);
        end
        cur_valid = 1'b1;
        cur_v     = v;
        cur_blz   = blz;
        cur_mask  = mask;
        check({name, " busy after"}, 32'(bus.busy), 32'd0);
        check({name, " done after"}, 32'(bus.done), 32'd0);
        if (use_const) check({name, " hex"}, 32'(bus.hex), 32'(const_exp));
        else           check({name, " hex"}, 32'(bus.hex), 32'(exp_disp()));
    endtask

    initial begin
        vec_t        vecs [6];
        logic [15:0] rv;
        logic        rb;
        logic [3:0]  rm;
        int          dones;
        int          bad;

        vecs[0] = '{16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h0805, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h12}};
        vecs[5] = '{16'hBCDE, 1'b0, {7'h03, 7'h46, 7'h21, 7'h06}};

        cur_valid      = 1'b0;
        cur_v          = '0;
        cur_blz        = 1'b0;
        cur_mask       = '0;
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.hex !== DARK || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        check("reset idle", 32'(bad), 32'd0);
        check("reset hex", 32'(bus.hex), 32'(DARK));

        for (int i = 0; i < 6; i++)
            load_and_check($sformatf("vec%0d", i), vecs[i].value, vecs[i].blz, 4'b0000,
                           1'b1, vecs[i].exp_hex);

        // Blink on digit 1 only, compared against the edge-count phase.
        load_and_check("blink load", 16'h12AF, 1'b0, 4'b0010, 1'b0, '0);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (bus.hex !== model_hex(16'h12AF, 1'b0, 4'b0010, phase_now())) bad++;
        end
        check("blink pattern", 32'(bad), 32'd0);

        for (int i = 0; i < 15; i++) begin
            rv = 16'($urandom);
            if (i % 3 == 0) rv = rv & 16'h00FF;
            rb = 1'($urandom_range(0, 1));
            rm = 4'($urandom);
            load_and_check($sformatf("rand%0d", i), rv, rb, rm, 1'b0, '0);
            repeat ($urandom_range(0, 5)) @(negedge clock);
            check($sformatf("rand%0d later", i), 32'(bus.hex), 32'(exp_disp()));
        end

        // Second load during scan is dropped.
        load_and_check("clear mask", 16'h0000, 1'b0, 4'b0000, 1'b1,
                       {7'h40, 7'h40, 7'h40, 7'h40});
        do_load(16'h1234, 1'b0, 4'b0000);
        dones = int'(bus.done);
        @(negedge clock);
        dones += int'(bus.done);
        bus.load  = 1'b1;
        bus.value = 16'h5678;
        @(negedge clock);
        bus.load = 1'b0;
        for (int c = 0; c < 10; c++) begin
            dones += int'(bus.done);
            @(negedge clock);
        end
        check("ignored load dones", 32'(dones), 32'd1);
        check("ignored load hex", 32'(bus.hex), 32'(model_hex(16'h1234, 1'b0, 4'b0000, 1'b0)));
        check("ignored load idle", 32'(bus.busy), 32'd0);
        cur_v = 16'h1234;

        // Reset in cycle 3 of a scan.
        do_load(16'hBCDE, 1'b0, 4'b0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset hex", 32'(bus.hex), 32'(DARK));
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cur_valid = 1'b0;
        dones = 0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            dones += int'(bus.done);
            if (bus.hex !== DARK || bus.busy !== 1'b0) bad++;
        end
        check("post reset dones", 32'(dones), 32'd0);
        check("post reset steady", 32'(bad), 32'd0);

        load_and_check("recover", vecs[0].value, vecs[0].blz, 4'b0000, 1'b1, vecs[0].exp_hex);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
